// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALUOp and ResultSrc encodings, plus the
// packed control bundle that travels down the pipeline registers.
package riscv_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_MEM  = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // A bubble is a plain add that writes nothing and never redirects the PC.
  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write:  1'b0,
    result_src: RESULT_ALU,
    mem_write:  1'b0,
    jump:       1'b0,
    branch:     1'b0,
    alu_src:    1'b0,
    alu_op:     ALUOP_ADD
  };

  function automatic ctrl_t kill_side_effects(input ctrl_t c);
    ctrl_t r;
    r           = c;
    r.reg_write = 1'b0;
    r.mem_write = 1'b0;
    r.jump      = 1'b0;
    r.branch    = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all ones and clears only on
// the asynchronous active-low reset.
module sat_counter
  #(parameter int W = 32)
  (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush (bubble) and a per-slot valid bit.
// Define ID_EX_STATS_EN to build the saturating stall/bubble event counters.
module id_ex_pipe_reg
  import riscv_pkg::*;
  #(
    parameter int XLEN = 32,
    parameter int REGW = 5
  )
  (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic            reg_write_d,
    input  logic            mem_write_d,
    input  logic            jump_d,
    input  logic            branch_d,
    input  logic            alu_src_d,
    input  logic [1:0]      result_src_d,
    input  logic [1:0]      alu_op_d,
    input  logic [2:0]      funct3_d,
    input  logic            op5_d,
    input  logic            funct7b5_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic [REGW-1:0] rd_d,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic            alu_src_e,
    output logic [1:0]      result_src_e,
    output logic [1:0]      alu_op_e,
    output logic [2:0]      funct3_e,
    output logic            op5_e,
    output logic            funct7b5_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [REGW-1:0] rs1_e,
    output logic [REGW-1:0] rs2_e,
    output logic [REGW-1:0] rd_e
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     bubble_cnt_o
`endif
  );

  ctrl_t ctrl_raw;
  ctrl_t ctrl_load;
  ctrl_t ctrl_q;

  assign ctrl_raw = '{
    reg_write:  reg_write_d,
    result_src: result_src_d,
    mem_write:  mem_write_d,
    jump:       jump_d,
    branch:     branch_d,
    alu_src:    alu_src_d,
    alu_op:     alu_op_d
  };

  // An invalid slot must never write state or redirect fetch downstream.
  assign ctrl_load = valid_d ? ctrl_raw : kill_side_effects(ctrl_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_BUBBLE;
      valid_e    <= 1'b0;
      funct3_e   <= '0;
      op5_e      <= 1'b0;
      funct7b5_e <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      imm_ext_e  <= '0;
      pc_plus4_e <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
    end else if (flush_e) begin
      ctrl_q     <= CTRL_BUBBLE;
      valid_e    <= 1'b0;
      funct3_e   <= '0;
      op5_e      <= 1'b0;
      funct7b5_e <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      imm_ext_e  <= '0;
      pc_plus4_e <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
    end else if (!stall_e) begin
      ctrl_q     <= ctrl_load;
      valid_e    <= valid_d;
      funct3_e   <= funct3_d;
      op5_e      <= op5_d;
      funct7b5_e <= funct7b5_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      pc_e       <= pc_d;
      imm_ext_e  <= imm_ext_d;
      pc_plus4_e <= pc_plus4_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= rd_d;
    end
  end

  assign reg_write_e  = ctrl_q.reg_write;
  assign result_src_e = ctrl_q.result_src;
  assign mem_write_e  = ctrl_q.mem_write;
  assign jump_e       = ctrl_q.jump;
  assign branch_e     = ctrl_q.branch;
  assign alu_src_e    = ctrl_q.alu_src;
  assign alu_op_e     = ctrl_q.alu_op;

`ifdef ID_EX_STATS_EN
  // A flush wins over a stall, so a combined request counts only as a bubble.
  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_e & ~flush_e),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(32)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_e),
    .count (bubble_cnt_o)
  );
`endif

endmodule
